utmi_rx_pkt_drv: RTL and testbench
==================================

Name: utmi_rx_pkt_drv

Overview:
Synthesizable UTMI receive-side packet driver sitting directly upstream of the USB function core's UTMI Rx pins (DataIn_pad_i, RxValid_pad_i, RxActive_pad_i, RxError_pad_i).
- Takes a packet command (PID plus payload length) and pulls payload bytes from a first-word-fall-through source.
- Serialises the packet with UTMI byte timing; for DATA PIDs it generates and appends CRC16.
- Used by bench and emulation top levels as the host/PHY stand-in feeding the core.

Parameters:
- BYTE_GAP, 1: cycles per byte slot; RxValid high for 1 cycle, then low for BYTE_GAP-1 cycles (1 = high speed, 40 = full-speed model). Legal range 1..255.
- LEAD, 2: cycles RxActive is high before the PID byte slot (0..15).
- TAIL, 2: cycles RxActive stays high after the last byte slot ends (0..15).
- LEN_W, 11: width of payload length (max 1024 bytes used).

Ports:
- clk_i  in  1  clock; UTMI domain
- rst_i  in  1  synchronous reset, active-high
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  block idle; command accepted when valid&&ready
- cmd_pid_i  in  4  PID[3:0]
- cmd_len_i  in  LEN_W  payload bytes after PID, excluding generated CRC16
- data_req_o  out  1  pop strobe; data_i consumed in the same cycle
- data_i  in  8  payload byte (FWFT head)
- DataIn_o  out  8  to core DataIn_pad_i
- RxValid_o  out  1  to core RxValid_pad_i
- RxActive_o  out  1  to core RxActive_pad_i
- RxError_o  out  1  to core RxError_pad_i
- done_o  out  1  one-cycle pulse when RxActive falls
- err_inj_i  in  1  error request (only with macro)
- err_idx_i  in  LEN_W  byte index for error (only with macro)

Behaviour:
- Reset: state IDLE.
  - cmd_ready_o=1; data_req_o=0; DataIn_o=8'h00; RxValid_o=0; RxActive_o=0; RxError_o=0; done_o=0.
  - Reset mid-packet aborts immediately; all outputs take their reset values on the next edge, with no done_o pulse.
- States and transitions: IDLE -> LEAD -> PID -> DATA -> CRC_LO -> CRC_HI -> TAIL -> IDLE.
  - Command accept in IDLE: latch pid and len; cmd_ready_o drops the next cycle.
  - LEAD: RxActive_o=1 for LEAD cycles. With LEAD=0, the PID slot starts the cycle after accept.
  - PID slot: DataIn_o={~pid,pid}.
  - DATA: len byte slots. DATA is skipped when len==0.
  - CRC_LO/CRC_HI: entered only for DATA PIDs (4'b0011, 4'b1011, 4'b0111, 4'b1111).
  - Other PIDs (tokens, SOF, handshakes): the caller supplies any CRC5/frame bytes as payload; no CRC is appended.
  - TAIL: RxActive_o stays 1 for TAIL cycles, then drops. done_o pulses in the cycle RxActive_o first reads 0. Return to IDLE with cmd_ready_o=1 that cycle.
- Byte slot: first cycle has RxValid_o=1 with DataIn_o valid. DataIn_o holds its value through the following BYTE_GAP-1 cycles with RxValid_o=0. Slots are back-to-back with no extra bubbles.
- Payload fetch: data_req_o=1 in the first cycle of each DATA slot; data_i is registered into DataIn_o that cycle. Exactly len pops per packet. The source must never be empty when popped (not checked).
- CRC16 (USB):
  - Reflected polynomial 0xA001, init 16'hFFFF, updated LSB-first over payload bytes only (PID excluded).
  - Transmitted value is ~crc: low byte in the CRC_LO slot, high byte in the CRC_HI slot.
  - Zero-length DATA packet sends CRC bytes 8'h00, 8'h00.
- Counters: byte counter LEN_W bits, compared for equality (len-1) to exit DATA. Gap counter 8 bits, wraps to 0 at BYTE_GAP-1.
- cmd_valid_i while busy: ignored; it is not queued.

Optional Feature:
- Macro UTMI_RX_ERR_INJ_EN.
- Defined:
  - err_inj_i is sampled at command accept.
  - If it is set, the slot whose index equals err_idx_i is replaced: PID = index 0, payload = 1..len, CRC_LO = len+1.
  - In that slot's first cycle: RxError_o=1 and RxValid_o=0. The slot's payload byte is still popped.
  - The FSM then goes directly to TAIL. No further bytes and no CRC are sent.
  - An index beyond the last slot is a no-op.
- Undefined: RxError_o is tied 0, and err_inj_i/err_idx_i are unused (ports remain).

Test Plan:
- ACK: pid=4'h2, len=0, BYTE_GAP=1 -> RxActive high LEAD cycles, single RxValid with DataIn=8'hD2, TAIL, then done_o pulse; no data_req_o.
- Empty DATA0: pid=4'h3, len=0 -> bytes C3, 00, 00 on consecutive cycles; zero pops.
- DATA1 payload 00 01 02 03 with BYTE_GAP=1 -> bytes 4B, 00, 01, 02, 03, crcL, crcH, where CRC matches the bench golden model; exactly 4 data_req_o pulses.
- IN token: pid=4'h9, len=2, payload 8'h81, 8'h58 with BYTE_GAP=40 -> RxValid pulses exactly 40 cycles apart; bytes 69, 81, 58; no CRC appended.
- Reset mid-DATA after 3 bytes of a 64-byte packet -> all outputs zero on the next edge, no done_o, cmd_ready_o=1; the next command runs normally.
- With UTMI_RX_ERR_INJ_EN: DATA0 len=8, err_idx_i=3 -> bytes C3, p0, p1, then RxError_o pulse in slot 3, then TAIL and done_o; 3 pops.

Source files
------------

// File: rtl/utmi_rx_pkt_drv.sv
// ---------------------------------------------------------------------------
// utmi_rx_pkt_drv
//
// UTMI receive-side packet driver. It acts as the host/PHY stand-in that
// feeds a USB function core's UTMI Rx pins. A command (PID + payload length)
// is accepted while idle. The driver then serialises the packet as
//   RxActive lead-in -> PID slot -> payload slots -> [CRC16 lo/hi] -> tail.
// Payload bytes come from a first-word-fall-through source. DATA PIDs get the
// USB CRC16 appended.
//
// Parameters:
//   BYTE_GAP  cycles per byte slot (RxValid high for the first cycle only)
//   LEAD      RxActive cycles before the PID slot
//   TAIL      RxActive cycles after the last slot
//   LEN_W     payload length width
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cmd_valid_i/ready_o     command handshake (ready only while idle)
//   cmd_pid_i, cmd_len_i    PID[3:0] and payload byte count (CRC excluded)
//   data_req_o, data_i      FWFT pop strobe and head byte
//   DataIn_o, RxValid_o,
//   RxActive_o, RxError_o   UTMI Rx signals towards the core
//   done_o                  one-cycle pulse in the first cycle RxActive is low
//   err_inj_i, err_idx_i    error injection request and slot index
//
// Optional feature: define UTMI_RX_ERR_INJ_EN to enable error injection.
// Without it RxError_o is tied low and err_inj_i/err_idx_i are ignored.
// ---------------------------------------------------------------------------
module utmi_rx_pkt_drv #(
    parameter int unsigned BYTE_GAP = 1,
    parameter int unsigned LEAD     = 2,
    parameter int unsigned TAIL     = 2,
    parameter int unsigned LEN_W    = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [3:0]       cmd_pid_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    output logic             data_req_o,
    input  logic [7:0]       data_i,
    output logic [7:0]       DataIn_o,
    output logic             RxValid_o,
    output logic             RxActive_o,
    output logic             RxError_o,
    output logic             done_o,
    input  logic             err_inj_i,
    input  logic [LEN_W-1:0] err_idx_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_PID,
        S_DATA,
        S_CRC_LO,
        S_CRC_HI,
        S_TAIL
    } state_t;

    localparam logic [7:0]       GAP_LAST  = 8'(BYTE_GAP - 1);
    localparam logic [3:0]       LEAD_LAST = 4'(LEAD - 1);
    localparam logic [3:0]       TAIL_LAST = 4'(TAIL - 1);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    state_t           state, state_n;
    logic [3:0]       pid_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] bcnt;
    logic [7:0]       gap;
    logic [3:0]       wait_cnt;
    logic [15:0]      crc_q;
    logic [7:0]       byte_q;
    logic             done_q;

    logic             in_slot, first, slot_end, is_data, accept;
    logic             err_hit, abort;
    logic [7:0]       slot_byte;
    state_t           end_state, post_pay;

    // USB CRC16, reflected polynomial, one byte processed LSB first.
    function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) r = r ^ 16'hA001;
        end
        return r;
    endfunction

    assign in_slot  = (state == S_PID) || (state == S_DATA) ||
                      (state == S_CRC_LO) || (state == S_CRC_HI);
    assign first    = in_slot && (gap == '0);
    assign slot_end = in_slot && (gap == GAP_LAST);
    assign is_data  = (pid_q[1:0] == 2'b11);
    assign accept   = (state == S_IDLE) && cmd_valid_i;

    assign end_state = (TAIL != 0) ? S_TAIL : S_IDLE;
    assign post_pay  = is_data ? S_CRC_LO : end_state;

    // Byte presented in the first cycle of the current slot. Payload comes
    // straight from the FWFT head so it is valid in the cycle it is popped.
    always_comb begin
        slot_byte = byte_q;
        case (state)
            S_PID:    slot_byte = {~pid_q, pid_q};
            S_DATA:   slot_byte = data_i;
            S_CRC_LO: slot_byte = ~crc_q[7:0];
            S_CRC_HI: slot_byte = ~crc_q[15:8];
            default:  slot_byte = byte_q;
        endcase
    end

`ifdef UTMI_RX_ERR_INJ_EN
    logic             err_en_q;
    logic [LEN_W-1:0] err_idx_q;
    logic             aborted_q;
    logic [LEN_W-1:0] slot_idx;
    logic             idx_ok;

    // Slot numbering: PID = 0, payload = 1..len, CRC_LO = len+1.
    always_comb begin
        idx_ok   = 1'b1;
        slot_idx = '0;
        case (state)
            S_PID:    slot_idx = '0;
            S_DATA:   slot_idx = bcnt + LEN_ONE;
            S_CRC_LO: slot_idx = len_q + LEN_ONE;
            default:  idx_ok   = 1'b0;
        endcase
        err_hit = err_en_q && first && idx_ok && (slot_idx == err_idx_q);
        abort   = err_hit || aborted_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_en_q  <= 1'b0;
            err_idx_q <= '0;
            aborted_q <= 1'b0;
        end else if (accept) begin
            err_en_q  <= err_inj_i;
            err_idx_q <= err_idx_i;
            aborted_q <= 1'b0;
        end else if (err_hit) begin
            aborted_q <= 1'b1;
        end
    end
`else
    logic unused_err;
    assign unused_err = ^{err_inj_i, err_idx_i};
    assign err_hit    = 1'b0;
    assign abort      = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n     = state;
        cmd_ready_o = (state == S_IDLE);
        RxActive_o  = (state != S_IDLE);
        RxValid_o   = first && !err_hit;
        RxError_o   = err_hit;
        data_req_o  = first && (state == S_DATA);
        DataIn_o    = first ? slot_byte : byte_q;
        done_o      = done_q;
        case (state)
            S_IDLE:   if (cmd_valid_i) state_n = (LEAD != 0) ? S_LEAD : S_PID;
            S_LEAD:   if (wait_cnt == LEAD_LAST) state_n = S_PID;
            S_PID: begin
                if (slot_end) begin
                    if (abort)              state_n = end_state;
                    else if (len_q != '0)   state_n = S_DATA;
                    else                    state_n = post_pay;
                end
            end
            S_DATA: begin
                if (slot_end) begin
                    if (abort)                           state_n = end_state;
                    else if (bcnt == len_q - LEN_ONE)    state_n = post_pay;
                end
            end
            S_CRC_LO: if (slot_end) state_n = abort ? end_state : S_CRC_HI;
            S_CRC_HI: if (slot_end) state_n = end_state;
            S_TAIL:   if (wait_cnt == TAIL_LAST) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pid_q    <= '0;
            len_q    <= '0;
            bcnt     <= '0;
            gap      <= '0;
            wait_cnt <= '0;
            crc_q    <= '1;
            byte_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state != S_IDLE) && (state_n == S_IDLE);

            if (accept) begin
                pid_q    <= cmd_pid_i;
                len_q    <= cmd_len_i;
                bcnt     <= '0;
                gap      <= '0;
                wait_cnt <= '0;
                crc_q    <= '1;
            end

            if (in_slot) gap <= slot_end ? '0 : gap + 8'd1;

            // Lead/tail counter restarts whenever the state changes.
            if (state == S_LEAD || state == S_TAIL)
                wait_cnt <= (state_n != state) ? '0 : wait_cnt + 4'd1;

            if (state == S_DATA && slot_end) bcnt <= bcnt + LEN_ONE;
            if (state == S_DATA && first)    crc_q <= crc16_upd(crc_q, data_i);

            if (first) byte_q <= slot_byte;
            if (state != S_IDLE && state_n == S_IDLE) byte_q <= '0;
        end
    end

endmodule

// File: tb/tb_utmi_rx_pkt_drv.sv
// ---------------------------------------------------------------------------
// Directed bench for utmi_rx_pkt_drv. Instance a uses BYTE_GAP=1 and
// instance b uses BYTE_GAP=40. Both share one FWFT source model. Each packet
// is captured cycle by cycle from the negedge after command acceptance
// (cycle 1) and compared with hand-derived byte streams and timing.
// ---------------------------------------------------------------------------
module tb_utmi_rx_pkt_drv;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        vld_a, vld_b;
    logic [3:0]  pid;
    logic [10:0] len;
    logic [7:0]  din;
    logic        err_inj;
    logic [10:0] err_idx;

    logic        rdy_a, req_a, rxv_a, rxa_a, rxe_a, done_a;
    logic        rdy_b, req_b, rxv_b, rxa_b, rxe_b, done_b;
    logic [7:0]  dat_a, dat_b;

    logic [7:0]  src [0:127];
    logic [6:0]  rd_ptr = '0;
    assign din = src[rd_ptr];
    always @(posedge clk) if (req_a || req_b) rd_ptr <= rd_ptr + 7'd1;

    utmi_rx_pkt_drv #(.BYTE_GAP(1), .LEAD(2), .TAIL(2), .LEN_W(11)) dut_a (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(vld_a), .cmd_ready_o(rdy_a),
        .cmd_pid_i(pid), .cmd_len_i(len), .data_req_o(req_a), .data_i(din),
        .DataIn_o(dat_a), .RxValid_o(rxv_a), .RxActive_o(rxa_a), .RxError_o(rxe_a),
        .done_o(done_a), .err_inj_i(err_inj), .err_idx_i(err_idx));

    utmi_rx_pkt_drv #(.BYTE_GAP(40), .LEAD(2), .TAIL(2), .LEN_W(11)) dut_b (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(vld_b), .cmd_ready_o(rdy_b),
        .cmd_pid_i(pid), .cmd_len_i(len), .data_req_o(req_b), .data_i(din),
        .DataIn_o(dat_b), .RxValid_o(rxv_b), .RxActive_o(rxa_b), .RxError_o(rxe_b),
        .done_o(done_b), .err_inj_i(1'b0), .err_idx_i(11'd0));

    logic       sel;
    logic       m_rdy, m_req, m_rxv, m_rxa, m_rxe, m_done;
    logic [7:0] m_dat;
    always_comb begin
        m_rdy  = sel ? rdy_b  : rdy_a;
        m_req  = sel ? req_b  : req_a;
        m_rxv  = sel ? rxv_b  : rxv_a;
        m_rxa  = sel ? rxa_b  : rxa_a;
        m_rxe  = sel ? rxe_b  : rxe_a;
        m_done = sel ? done_b : done_a;
        m_dat  = sel ? dat_b  : dat_a;
    end

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  got_b[$];
    int unsigned got_c[$];
    logic [7:0]  exp_q[$];
    int unsigned pops, act, errs, err_cyc, done_cyc, cyc;
    logic        rdy_done, act_done, got_done, seen;
    logic [6:0]  base;
    logic [15:0] crc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Golden CRC16 step: fold the whole byte in, then shift eight times.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    task automatic load(input int n, input logic [7:0] first_val);
        base = rd_ptr;
        for (int k = 0; k < n; k++) src[base + 7'(k)] = first_val + 8'(k);
    endtask

    // Issue a command at a negedge, then capture until done_o or budget.
    task automatic run_pkt(input logic use_b, input logic [3:0] p, input logic [10:0] l,
                           input int unsigned budget);
        sel = use_b;
        pid = p;
        len = l;
        check("ready_before_cmd", m_rdy, 1);
        if (use_b) vld_b = 1'b1; else vld_a = 1'b1;
        @(negedge clk);
        vld_a = 1'b0;
        vld_b = 1'b0;
        got_b.delete();
        got_c.delete();
        pops = 0; act = 0; errs = 0; err_cyc = 0; done_cyc = 0;
        cyc = 1; got_done = 1'b0; rdy_done = 1'b0; act_done = 1'b1;
        while (!got_done && cyc <= budget) begin
            if (m_rxv) begin got_b.push_back(m_dat); got_c.push_back(cyc); end
            if (m_req) pops++;
            if (m_rxe) begin errs++; err_cyc = cyc; end
            if (m_rxa) act++;
            if (m_done) begin
                got_done = 1'b1; done_cyc = cyc; rdy_done = m_rdy; act_done = m_rxa;
            end
            if (!got_done) begin @(negedge clk); cyc++; end
        end
        check("done_within_budget", got_done, 1);
    endtask

    task automatic check_bytes(input string tag, input int unsigned start, input int unsigned step);
        check({tag, "_count"}, got_b.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), got_b[i], exp_q[i]);
            check($sformatf("%s_cycle%0d", tag, i), got_c[i], start + i * step);
        end
    endtask

    initial begin
        rst = 1'b1; vld_a = 1'b0; vld_b = 1'b0; pid = '0; len = '0;
        err_inj = 1'b0; err_idx = '0; sel = 1'b0;
        for (int k = 0; k < 128; k++) src[k] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ready", rdy_a, 1);
        check("rst_req", req_a, 0);
        check("rst_datain", dat_a, 8'h00);
        check("rst_rxvalid", rxv_a, 0);
        check("rst_rxactive", rxa_a, 0);
        check("rst_rxerror", rxe_a, 0);
        check("rst_done", done_a, 0);
        rst = 1'b0;
        @(negedge clk);

        // ACK handshake
        run_pkt(1'b0, 4'h2, 11'd0, 50);
        exp_q = '{8'hD2};
        check_bytes("ack", 3, 1);
        check("ack_done_cycle", done_cyc, 6);
        check("ack_active_cycles", act, 5);
        check("ack_pops", pops, 0);
        check("ack_ready_at_done", rdy_done, 1);
        check("ack_active_at_done", act_done, 0);
        check("ack_rxerror", errs, 0);

        // Zero-length DATA0
        run_pkt(1'b0, 4'h3, 11'd0, 50);
        exp_q = '{8'hC3, 8'h00, 8'h00};
        check_bytes("data0_empty", 3, 1);
        check("data0_empty_pops", pops, 0);
        check("data0_empty_done_cycle", done_cyc, 8);

        // DATA1 with payload 00 01 02 03
        load(4, 8'h00);
        run_pkt(1'b0, 4'hB, 11'd4, 50);
        crc = 16'hFFFF;
        for (int k = 0; k < 4; k++) crc = crc_step(crc, 8'(k));
        exp_q = '{8'h4B, 8'h00, 8'h01, 8'h02, 8'h03};
        exp_q.push_back(~crc[7:0]);
        exp_q.push_back(~crc[15:8]);
        check_bytes("data1", 3, 1);
        check("data1_pops", pops, 4);
        check("data1_done_cycle", done_cyc, 12);
        check("data1_active_cycles", act, 11);

        // IN token on the 40-cycle slot instance
        load(2, 8'h00);
        src[base] = 8'h81;
        src[base + 7'd1] = 8'h58;
        run_pkt(1'b1, 4'h9, 11'd2, 300);
        exp_q = '{8'h69, 8'h81, 8'h58};
        check_bytes("in_tok", 3, 40);
        check("in_tok_pops", pops, 2);
        check("in_tok_done_cycle", done_cyc, 125);
        check("in_tok_active_cycles", act, 124);

        // Reset in the middle of a 64-byte DATA0
        load(64, 8'h10);
        sel = 1'b0; pid = 4'h3; len = 11'd64; vld_a = 1'b1;
        @(negedge clk);
        vld_a = 1'b0;
        pops = 0; cyc = 0;
        while (pops < 3 && cyc < 40) begin
            if (req_a) pops++;
            if (pops < 3) begin @(negedge clk); cyc++; end
        end
        check("mid_rst_pops_seen", pops, 3);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rxactive", rxa_a, 0);
        check("mid_rst_rxvalid", rxv_a, 0);
        check("mid_rst_datain", dat_a, 8'h00);
        check("mid_rst_req", req_a, 0);
        check("mid_rst_done", done_a, 0);
        check("mid_rst_ready", rdy_a, 1);
        rst = 1'b0;
        seen = 1'b0;
        repeat (5) begin @(negedge clk); if (done_a || rxa_a) seen = 1'b1; end
        check("mid_rst_quiet_after", seen, 0);

        load(4, 8'h00);
        run_pkt(1'b0, 4'hB, 11'd4, 50);
        exp_q = '{8'h4B, 8'h00, 8'h01, 8'h02, 8'h03};
        exp_q.push_back(~crc[7:0]);
        exp_q.push_back(~crc[15:8]);
        check_bytes("post_rst", 3, 1);
        check("post_rst_pops", pops, 4);

`ifdef UTMI_RX_ERR_INJ_EN
        // Error injected in slot 3 of an 8-byte DATA0
        load(8, 8'hA0);
        err_inj = 1'b1; err_idx = 11'd3;
        run_pkt(1'b0, 4'h3, 11'd8, 50);
        err_inj = 1'b0; err_idx = '0;
        exp_q = '{8'hC3, 8'hA0, 8'hA1};
        check_bytes("err_inj", 3, 1);
        check("err_inj_pulses", errs, 1);
        check("err_inj_cycle", err_cyc, 6);
        check("err_inj_pops", pops, 3);
        check("err_inj_done_cycle", done_cyc, 9);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
